// File: rtl/dsc_mul_seq_if.sv
// Handshake bundle for dsc_mul_seq: operand-triple input channel and
// result output channel. The sequencer connects through the slave modport,
// the producer/consumer side through the master modport.
interface dsc_mul_seq_if #(
  parameter int NUM_INPUTS = 3,
  parameter int NUM_BITS   = 10,
  parameter int CW         = 34
);
  // Upstream operand channel
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_BITS-1:0]            in_a;
  logic [NUM_BITS-1:0]            in_b;
  logic [NUM_BITS-1:0]            in_c;

  // Downstream result channel
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_INPUTS*NUM_BITS-1:0] out_z;
  logic [CW-1:0]                  out_cycles;
  logic                           out_timeout;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_z, out_cycles, out_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_z, out_cycles, out_timeout
  );
endinterface

// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture stage around dsc_mul.
// Accepts an operand triple, clears dsc_mul for one cycle, enables it until
// ov (or a RUN-cycle timeout), then holds the captured product and cycle
// count on the output channel until the consumer takes it.
module dsc_mul_seq #(
  parameter int              NUM_INPUTS = 3,
  parameter int              NUM_BITS   = 10,
  parameter int              CW         = 34,
  parameter longint unsigned TIMEOUT    = 64'd1073741840
) (
  input  logic                           clk,
  input  logic                           rst,
  dsc_mul_seq_if.slave                   io,
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov,
  output logic                           busy
);

  localparam int            ZW        = NUM_INPUTS * NUM_BITS;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;

  logic                accept_s;
  logic                cap_ov_s;
  logic                cap_to_s;
  logic [CW-1:0]       cnt_inc_s;

  logic [CW-1:0]       cnt_r;
  logic                mul_rst_r;
  logic                mul_en_r;
  logic                busy_r;
  logic                out_valid_r;
  logic [NUM_BITS-1:0] mul_a_r;
  logic [NUM_BITS-1:0] mul_b_r;
  logic [NUM_BITS-1:0] mul_c_r;
  logic [ZW-1:0]       out_z_r;
  logic [CW-1:0]       out_cycles_r;
  logic                out_timeout_r;

  // Next-state decode plus the accept/capture strobes used by the datapath
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    cap_ov_s     = 1'b0;
    cap_to_s     = 1'b0;
    // Saturating increment: the counter may reach TIMEOUT but never wraps
    if (cnt_r == TIMEOUT_C) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + ONE_C;
    end
    case (state_r)
      IDLE: begin
        if (io.in_valid) begin
          accept_s     = 1'b1;
          next_state_s = CLR;
        end else begin
          next_state_s = IDLE;
        end
      end
      CLR: begin
        next_state_s = RUN;
      end
      RUN: begin
        // ov wins over timeout when both land on the same cycle
        if (mul_ov) begin
          cap_ov_s     = 1'b1;
          next_state_s = DONE;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          cap_to_s     = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered control outputs, decoded from the state being entered so they
  // line up with the state itself
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_rst_r   <= 1'b1;
      mul_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      mul_rst_r   <= (next_state_s != RUN);
      mul_en_r    <= (next_state_s == RUN);
      busy_r      <= (next_state_s != IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Operand latch: held stable from CLR through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_r <= {NUM_BITS{1'b0}};
      mul_b_r <= {NUM_BITS{1'b0}};
      mul_c_r <= {NUM_BITS{1'b0}};
    end else if (accept_s) begin
      mul_a_r <= io.in_a;
      mul_b_r <= io.in_b;
      mul_c_r <= io.in_c;
    end else begin
      mul_a_r <= mul_a_r;
      mul_b_r <= mul_b_r;
      mul_c_r <= mul_c_r;
    end
  end

  // RUN-cycle counter: cleared on accept, advances once per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO_C;
    end else if (accept_s) begin
      cnt_r <= ZERO_C;
    end else if (state_r == RUN) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture: retained after the handshake until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      out_z_r       <= {ZW{1'b0}};
      out_cycles_r  <= ZERO_C;
      out_timeout_r <= 1'b0;
    end else if (cap_ov_s) begin
      out_z_r       <= mul_z;
      out_cycles_r  <= cnt_inc_s;
      out_timeout_r <= 1'b0;
    end else if (cap_to_s) begin
      out_z_r       <= {ZW{1'b0}};
      out_cycles_r  <= TIMEOUT_C;
      out_timeout_r <= 1'b1;
    end else begin
      out_z_r       <= out_z_r;
      out_cycles_r  <= out_cycles_r;
      out_timeout_r <= out_timeout_r;
    end
  end

  // in_ready is the one output decoded straight from state
  assign io.in_ready    = (state_r == IDLE);
  assign io.out_valid   = out_valid_r;
  assign io.out_z       = out_z_r;
  assign io.out_cycles  = out_cycles_r;
  assign io.out_timeout = out_timeout_r;

  assign mul_rst = mul_rst_r;
  assign mul_en  = mul_en_r;
  assign mul_a   = mul_a_r;
  assign mul_b   = mul_b_r;
  assign mul_c   = mul_c_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed self-checking bench for dsc_mul_seq with a behavioural dsc_mul
// stub (ov after a programmable number of enabled cycles, z = a*b*c).
module tb_dsc_mul_seq;

  localparam int NB = 10;
  localparam int NI = 3;
  localparam int CW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          mul_rst;
  logic          mul_en;
  logic [NB-1:0] mul_a;
  logic [NB-1:0] mul_b;
  logic [NB-1:0] mul_c;
  logic [29:0]   mul_z;
  logic          mul_ov;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // stub controls
  int stub_n     = 5;
  bit stub_never = 1'b0;
  int stub_cnt   = 0;

  dsc_mul_seq_if #(.NUM_INPUTS(NI), .NUM_BITS(NB), .CW(CW)) bus ();

  dsc_mul_seq #(
    .NUM_INPUTS(NI), .NUM_BITS(NB), .CW(CW), .TIMEOUT(64'd8)
  ) dut (
    .clk(clk), .rst(rst), .io(bus),
    .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_z(mul_z), .mul_ov(mul_ov), .busy(busy)
  );

  always #5 clk = ~clk;

  // dsc_mul stub: counts enabled cycles, clears on its rst
  always @(posedge clk) begin
    if (mul_rst) stub_cnt <= 0;
    else if (mul_en) stub_cnt <= stub_cnt + 1;
  end

  assign mul_ov = !stub_never && !mul_rst && mul_en && ((stub_cnt + 1) >= stub_n);
  assign mul_z  = 30'({20'd0, mul_a} * {20'd0, mul_b} * {20'd0, mul_c});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until out_valid, returning whether it arrived
  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  // Issue one triple and follow it to DONE, checking sequencing and result
  task automatic run_op(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [NB-1:0] c, input int n, input bit never,
                        input logic [63:0] exp_z, input logic [63:0] exp_cyc,
                        input logic exp_to);
    int pre;
    int en_cnt;
    int guard;
    bit got;
    stub_n     = n;
    stub_never = never;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_clr_ctl"}, 64'({mul_rst, mul_en, bus.in_ready}), 64'b100);
    check({tag, "_ops"}, 64'({mul_a, mul_b, mul_c}), 64'({a, b, c}));
    pre = 1; en_cnt = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (bus.out_valid) got = 1'b1;
      else if (mul_en) en_cnt++;
      else if (en_cnt == 0) pre++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_clr_len"}, 64'(pre), 64'd1);
    check({tag, "_en_len"}, 64'(en_cnt), exp_cyc);
    check({tag, "_z"}, 64'(bus.out_z), exp_z);
    check({tag, "_cycles"}, 64'(bus.out_cycles), exp_cyc);
    check({tag, "_to"}, 64'(bus.out_timeout), 64'(exp_to));
    check({tag, "_done_ctl"}, 64'({mul_rst, mul_en, busy}), 64'b101);
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_rel"}, 64'({bus.out_valid, bus.in_ready, busy}), 64'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit stable;
    bit seen;
    logic [29:0] bb_exp [3];
    logic [NB-1:0] bb_a [3];
    logic [NB-1:0] bb_b [3];
    logic [NB-1:0] bb_c [3];
    bb_a = '{10'd1, 10'd1023, 10'd0};
    bb_b = '{10'd2, 10'd1023, 10'd7};
    bb_c = '{10'd3, 10'd1023, 10'd9};
    bb_exp = '{30'd6, 30'd1070599167, 30'd0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = 10'd0; bus.in_b = 10'd0; bus.in_c = 10'd0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_ctl", 64'({bus.in_ready, mul_rst, mul_en, busy, bus.out_valid}), 64'b11000);
    check("rst_out", 64'({bus.out_z, bus.out_cycles, bus.out_timeout}), 64'd0);
    check("rst_ops", 64'({mul_a, mul_b, mul_c}), 64'd0);

    // basic
    run_op("basic", 10'd15, 10'd15, 10'd15, 5, 1'b0, 64'd3375, 64'd5, 1'b0);
    release_out("basic");
    check("basic_keep", 64'(bus.out_z), 64'd3375);

    // back-pressure: hold out_ready low, present a new triple meanwhile
    run_op("bp", 10'd3, 10'd4, 10'd5, 3, 1'b0, 64'd60, 64'd3, 1'b0);
    stub_n = 2;
    bus.in_a = 10'd5; bus.in_b = 10'd6; bus.in_c = 10'd7; bus.in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.out_z != 30'd60 || bus.in_ready || mul_a != 10'd3) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    release_out("bp");
    check("bp_not_yet", 64'(mul_a), 64'd3);
    tick();
    bus.in_valid = 1'b0;
    check("bp_accept", 64'({mul_a, bus.in_ready}), 64'({10'd5, 1'b0}));
    wait_out(got);
    check("bp2_done", 64'(got), 64'd1);
    check("bp2_z", 64'(bus.out_z), 64'd210);
    check("bp2_cycles", 64'(bus.out_cycles), 64'd2);
    release_out("bp2");

    // back-to-back with in_valid held and out_ready high
    stub_n = 4;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_a = bb_a[k]; bus.in_b = bb_b[k]; bus.in_c = bb_c[k];
      bus.in_valid = 1'b1;
      seen = 1'b0;
      for (int g = 0; g < 20 && !bus.in_ready; g++) tick();
      check($sformatf("b2b%0d_idle_rst", k), 64'({bus.in_ready, mul_rst}), 64'b11);
      tick();
      wait_out(got);
      check($sformatf("b2b%0d_z", k), 64'({got, bus.out_z}), 64'({1'b1, bb_exp[k]}));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;

    // timeout, then a normal operation
    run_op("tmo", 10'd9, 10'd9, 10'd9, 1, 1'b1, 64'd0, 64'd8, 1'b1);
    release_out("tmo");
    run_op("after", 10'd2, 10'd3, 10'd4, 3, 1'b0, 64'd24, 64'd3, 1'b0);
    release_out("after");

    // ov on the same cycle the counter hits TIMEOUT
    run_op("simul", 10'd10, 10'd10, 10'd10, 8, 1'b0, 64'd1000, 64'd8, 1'b0);
    release_out("simul");

    // reset during RUN cycle 3
    stub_n = 6; stub_never = 1'b0;
    bus.in_a = 10'd7; bus.in_b = 10'd7; bus.in_c = 10'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_run", 64'({mul_en, busy}), 64'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", 64'({busy, mul_rst, mul_en, bus.out_valid, bus.in_ready}), 64'b01001);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid || busy) seen = 1'b1;
    end
    check("mid_no_result", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
